// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encoding and timeout sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_arbiter_pkg;

    // Width of the per-phase watchdog counter and its default limit.
    localparam int TIMEOUT_W       = 16;
    localparam int TIMEOUT_DEFAULT = 65535;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ requesters.
// Latency: gnt 1 cycle after req sampled in IDLE; done 1 cycle after spi_ss returns high.
// Backpressure: waits in IDLE while spi_ss is low; each phase aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   req / tx_data         per-requester level request and byte to send
//   gnt / done            one-hot grant (grant..done) and one-cycle completion pulse
//   rx_data / timeout_err received byte (held until next done) and abort flag
//   spi_start / spi_tx    start level and byte towards spi_master
//   spi_rx / spi_ss       received byte and active-low busy from spi_master
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   tx_data,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rx_data,
    output logic                timeout_err,
    output logic                spi_start,
    output logic [7:0]          spi_tx,
    input  logic [7:0]          spi_rx,
    input  logic                spi_ss
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]      ONE      = NREQ'(1);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NREQ - 1);

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        win;
    logic [TIMEOUT_W-1:0] cnt;
    logic [IW-1:0]        pick;
    logic [7:0]           pick_byte;
    logic                 cnt_hit;

    // First set request at or after p, wrapping modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        pick      = rr_pick(req, ptr);
        pick_byte = tx_data[8*int'(pick) +: 8];
        cnt_hit   = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            win         <= '0;
            cnt         <= '0;
            gnt         <= '0;
            done        <= '0;
            rx_data     <= 8'h00;
            timeout_err <= 1'b0;
            spi_start   <= 1'b0;
            spi_tx      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    // A low spi_ss means the master is still busy (e.g. after a
                    // reset mid-transfer), so no new grant until it is released.
                    if (|req && spi_ss) begin
                        state     <= START;
                        win       <= pick;
                        gnt       <= ONE << pick;
                        spi_tx    <= pick_byte;
                        cnt       <= '0;
                        spi_start <= 1'b1;
                    end
                end
                START: begin
                    if (!spi_ss) begin
                        state     <= XFER;
                        spi_start <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt_hit) begin
                        state       <= DONE;
                        spi_start   <= 1'b0;
                        done        <= gnt;
                        timeout_err <= 1'b1;
                        rx_data     <= 8'h00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (spi_ss) begin
                        state   <= DONE;
                        done    <= gnt;
                        rx_data <= spi_rx;
                    end else if (cnt_hit) begin
                        state       <= DONE;
                        done        <= gnt;
                        timeout_err <= 1'b1;
                        rx_data     <= 8'h00;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The DONE+IDLE pair guarantees two spi_start-low cycles
                    // between consecutive transfers.
                    state       <= IDLE;
                    done        <= '0;
                    gnt         <= '0;
                    timeout_err <= 1'b0;
                    ptr         <= (win == LAST_IDX) ? '0 : win + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter with a behavioural spi_master stand-in.
// Latency: n/a.
// Backpressure: slave stand-in holds spi_ss low for xfer_len cycles per start.
module tb_spi_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] tx_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        rx_data;
    logic              timeout_err;
    logic              spi_start;
    logic [7:0]        spi_tx;
    logic [7:0]        spi_rx;
    logic              spi_ss;

    spi_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .tx_data     (tx_data),
        .gnt         (gnt),
        .done        (done),
        .rx_data     (rx_data),
        .timeout_err (timeout_err),
        .spi_start   (spi_start),
        .spi_tx      (spi_tx),
        .spi_rx      (spi_rx),
        .spi_ss      (spi_ss)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic [7:0] rx;
        logic       tmo;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic [7:0] rx;
        logic [3:0] gnt_exp;
    } vec_t;
    vec_t vecs[4];

    // Slave stand-in controls
    logic       slave_en;
    int         xfer_len;
    logic [7:0] slave_rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] tx, input logic [7:0] rx, input logic tmo);
        exp_t e;
        e.idx = idx; e.tx = tx; e.rx = rx; e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic set_tx(input int i, input logic [7:0] b);
        tx_data[i*8 +: 8] = b;
    endtask

    task automatic wait_done(input int limit);
        bit got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (|done) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_done actual=no_done required=done_within_%0d", limit);
        end
    endtask

    task automatic wait_start(input int limit);
        bit got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (spi_start) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_start actual=no_start required=start_within_%0d", limit);
        end
    endtask

    task automatic wait_ss_low(input int limit);
        bit got = 1'b0;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk); #1;
            if (!spi_ss) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_ss_low actual=high required=low_within_%0d", limit);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},       gnt,         0);
        chk({tag, "_done"},      done,        0);
        chk({tag, "_rx_data"},   rx_data,     0);
        chk({tag, "_tmo"},       timeout_err, 0);
        chk({tag, "_spi_start"}, spi_start,   0);
        chk({tag, "_spi_tx"},    spi_tx,      0);
    endtask

    // spi_master stand-in: on a start request, holds spi_ss low for
    // xfer_len cycles, then returns slave_rx and releases spi_ss.
    initial begin
        spi_ss = 1'b1;
        spi_rx = 8'h00;
        forever begin
            @(negedge clk);
            if (slave_en && spi_start && spi_ss) begin
                spi_ss = 1'b0;
                repeat (xfer_len) @(negedge clk);
                spi_rx = slave_rx;
                spi_ss = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops on every done pulse, plus protocol invariants.
    initial begin
        exp_t e;
        logic prev_done  = 1'b0;
        logic prev_start = 1'b0;
        int   low_run    = 100;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (|done) begin
                    chk("done_one_cycle", prev_done, 0);
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done actual=%0b required=no_done", done);
                    end else begin
                        e = sb.pop_front();
                        chk("done_vec",  done,        32'd1 << e.idx);
                        chk("gnt_held",  gnt,         done);
                        chk("spi_tx",    spi_tx,      e.tx);
                        chk("rx_data",   rx_data,     e.rx);
                        chk("tmo_err",   timeout_err, e.tmo);
                    end
                end else if (|gnt) begin
                    chk("tmo_outside_done", timeout_err, 0);
                end
                if (|gnt) chk("gnt_onehot", $onehot(gnt), 1);
                if (spi_start && !prev_start) chk("start_gap_ge2", low_run >= 2, 1);
                low_run = spi_start ? 0 : low_run + 1;
            end
            prev_done  = |done;
            prev_start = spi_start;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0] = '{idx: 2, tx: 8'hA5, rx: 8'h3C, gnt_exp: 4'b0100};
        vecs[1] = '{idx: 0, tx: 8'h11, rx: 8'h22, gnt_exp: 4'b0001};
        vecs[2] = '{idx: 3, tx: 8'hFE, rx: 8'h01, gnt_exp: 4'b1000};
        vecs[3] = '{idx: 1, tx: 8'h80, rx: 8'h7F, gnt_exp: 4'b0010};

        rst = 1'b1; req = '0; tx_data = '0;
        slave_en = 1'b1; xfer_len = 3; slave_rx = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single-requester table: gnt one cycle after req, byte round trip.
        for (int v = 0; v < 4; v++) begin
            set_tx(vecs[v].idx, vecs[v].tx);
            slave_rx = vecs[v].rx;
            push_exp(vecs[v].idx, vecs[v].tx, vecs[v].rx, 1'b0);
            req[vecs[v].idx] = 1'b1;
            @(negedge clk);
            chk("tbl_gnt",       gnt,       vecs[v].gnt_exp);
            chk("tbl_spi_tx",    spi_tx,    vecs[v].tx);
            chk("tbl_spi_start", spi_start, 1);
            wait_done(200);
            req = '0;
            @(negedge clk);
        end

        // All requesters held after reset: order 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_tx(i, 8'h10 + 8'(i));
        slave_rx = 8'h5A;
        for (int k = 0; k < 5; k++) push_exp(k % NREQ, 8'h10 + 8'(k % NREQ), 8'h5A, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(200);
        req = '0;
        @(negedge clk);

        // No slave response: abort 16 cycles after START.
        slave_en = 1'b0;
        set_tx(1, 8'h77);
        push_exp(1, 8'h77, 8'h00, 1'b1);
        req = 4'b0010;
        wait_start(20);
        t0 = cyc;
        wait_done(100);
        chk("tmo_latency", cyc - t0, TMO);
        req = '0;
        @(negedge clk);
        slave_en = 1'b1;

        // Request dropped and byte changed mid-transfer: original byte kept.
        xfer_len = 6;
        set_tx(3, 8'hC3);
        slave_rx = 8'h96;
        push_exp(3, 8'hC3, 8'h96, 1'b0);
        req = 4'b1000;
        wait_ss_low(50);
        @(negedge clk);
        req = '0;
        set_tx(3, 8'h99);
        wait_done(100);
        @(negedge clk);

        // Persistent single requester: back-to-back grants.
        xfer_len = 2;
        set_tx(0, 8'h42);
        slave_rx = 8'h24;
        for (int k = 0; k < 3; k++) push_exp(0, 8'h42, 8'h24, 1'b0);
        req = 4'b0001;
        for (int k = 0; k < 3; k++) wait_done(100);
        req = '0;
        @(negedge clk);

        // Reset during XFER, then a new request waits for spi_ss release.
        xfer_len = 10;
        set_tx(2, 8'hE7);
        slave_rx = 8'h4B;
        req = 4'b0100;
        wait_ss_low(50);
        repeat (2) @(negedge clk);
        chk("pre_rst_gnt", gnt, 4'b0100);
        rst = 1'b1;
        req = 4'b0010;
        set_tx(1, 8'h3D);
        @(negedge clk);
        chk_reset_outputs("midrst");
        push_exp(1, 8'h3D, 8'h4B, 1'b0);
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (spi_ss) break;
            chk("no_gnt_ss_low", gnt, 0);
        end
        @(negedge clk);
        chk("gnt_after_ss_high", gnt, 4'b0010);
        wait_done(100);
        req = '0;
        repeat (3) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
